baccarat_deal_fsm: RTL and testbench

- Dealing sequencer for one baccarat round. Sits directly upstream of the two hand scorers.
- Takes cards one at a time from the card source and holds them as three player and three dealer card registers, which feed the scorers.
- Reads back the player and dealer scores to apply the natural, player-draw and banker-draw rules, then flags the winner.

---
 rtl/baccarat_deal_fsm.sv | 161 ++++++++++++++++
 tb/tb_baccarat_deal_fsm.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_deal_fsm.sv
// Baccarat round dealing sequencer: loads player/dealer cards and applies the drawing rules.
// Optional BACCARAT_CARD_CHECK_EN rejects out-of-range ranks and adds the bad_card pulse.
module baccarat_deal_fsm (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       start,
  input  logic       card_valid,
  input  logic [3:0] new_card,
  output logic       card_req,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic       player_win,
  output logic       dealer_win,
`ifdef BACCARAT_CARD_CHECK_EN
  output logic       bad_card,
`endif
  output logic       done
);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StP1    = 4'd1;
  localparam logic [3:0] StD1    = 4'd2;
  localparam logic [3:0] StP2    = 4'd3;
  localparam logic [3:0] StD2    = 4'd4;
  localparam logic [3:0] StEval  = 4'd5;
  localparam logic [3:0] StP3    = 4'd6;
  localparam logic [3:0] StD3    = 4'd7;
  localparam logic [3:0] StScore = 4'd8;
  localparam logic [3:0] StDone  = 4'd9;

  logic [3:0] state_q, state_d;
  logic [3:0] pc1_q, pc1_d, pc2_q, pc2_d, pc3_q, pc3_d;
  logic [3:0] dc1_q, dc1_d, dc2_q, dc2_d, dc3_q, dc3_d;
  logic       pwin_q, pwin_d, dwin_q, dwin_d;
  // Set once pcard3 is loaded so P3 spends one cycle letting the scores settle.
  logic       settle_q, settle_d;
  logic       card_ok, load, banker_draw;
  logic [3:0] t;

`ifdef BACCARAT_CARD_CHECK_EN
  assign card_ok  = (new_card != 4'd0) && (new_card <= 4'd13);
  assign bad_card = card_req && card_valid && !card_ok;
`else
  assign card_ok  = 1'b1;
`endif

  assign card_req = (state_q == StP1) || (state_q == StD1) || (state_q == StP2) ||
                    (state_q == StD2) || (state_q == StD3) || ((state_q == StP3) && !settle_q);
  assign load     = card_req && card_valid && card_ok;

  always_comb begin
    t           = (pc3_q <= 4'd9) ? pc3_q : 4'd0;
    banker_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (t != 4'd8);
      4'd4:             banker_draw = (t >= 4'd2) && (t <= 4'd7);
      4'd5:             banker_draw = (t >= 4'd4) && (t <= 4'd7);
      4'd6:             banker_draw = (t >= 4'd6) && (t <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc1_d    = pc1_q;
    pc2_d    = pc2_q;
    pc3_d    = pc3_q;
    dc1_d    = dc1_q;
    dc2_d    = dc2_q;
    dc3_d    = dc3_q;
    pwin_d   = pwin_q;
    dwin_d   = dwin_q;
    settle_d = settle_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pc1_d    = 4'd0;
          pc2_d    = 4'd0;
          pc3_d    = 4'd0;
          dc1_d    = 4'd0;
          dc2_d    = 4'd0;
          dc3_d    = 4'd0;
          pwin_d   = 1'b0;
          dwin_d   = 1'b0;
          settle_d = 1'b0;
          state_d  = StP1;
        end
      end
      StP1: if (load) begin pc1_d = new_card; state_d = StD1; end
      StD1: if (load) begin dc1_d = new_card; state_d = StP2; end
      StP2: if (load) begin pc2_d = new_card; state_d = StD2; end
      StD2: if (load) begin dc2_d = new_card; state_d = StEval; end
      StEval: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) state_d = StScore;
        else if (pscore <= 4'd5)                  state_d = StP3;
        else if (dscore <= 4'd5)                  state_d = StD3;
        else                                      state_d = StScore;
      end
      StP3: begin
        if (settle_q) begin
          settle_d = 1'b0;
          state_d  = banker_draw ? StD3 : StScore;
        end else if (load) begin
          pc3_d    = new_card;
          settle_d = 1'b1;
        end
      end
      StD3: if (load) begin dc3_d = new_card; state_d = StScore; end
      StScore: begin
        pwin_d  = (pscore >= dscore);
        dwin_d  = (dscore >= pscore);
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= StIdle;
      pc1_q    <= 4'd0;
      pc2_q    <= 4'd0;
      pc3_q    <= 4'd0;
      dc1_q    <= 4'd0;
      dc2_q    <= 4'd0;
      dc3_q    <= 4'd0;
      pwin_q   <= 1'b0;
      dwin_q   <= 1'b0;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc1_q    <= pc1_d;
      pc2_q    <= pc2_d;
      pc3_q    <= pc3_d;
      dc1_q    <= dc1_d;
      dc2_q    <= dc2_d;
      dc3_q    <= dc3_d;
      pwin_q   <= pwin_d;
      dwin_q   <= dwin_d;
      settle_q <= settle_d;
    end
  end

  assign pcard1     = pc1_q;
  assign pcard2     = pc2_q;
  assign pcard3     = pc3_q;
  assign dcard1     = dc1_q;
  assign dcard2     = dc2_q;
  assign dcard3     = dc3_q;
  assign player_win = pwin_q;
  assign dealer_win = dwin_q;
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// Bench for baccarat_deal_fsm: behavioural hand scorers plus a rule-model scoreboard per round.
module tb_baccarat_deal_fsm;

  logic       slow_clock, resetb, start, card_valid, card_req;
  logic [3:0] new_card, pscore, dscore;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic       player_win, dealer_win, done;
`ifdef BACCARAT_CARD_CHECK_EN
  logic       bad_card;
`endif

  typedef struct packed {
    logic [3:0] p1, d1, p2, d2, p3, d3;
    logic       pw, dw;
    logic [3:0] n;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  baccarat_deal_fsm dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .start      (start),
    .card_valid (card_valid),
    .new_card   (new_card),
    .card_req   (card_req),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .player_win (player_win),
    .dealer_win (dealer_win),
`ifdef BACCARAT_CARD_CHECK_EN
    .bad_card   (bad_card),
`endif
    .done       (done)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  function automatic int cv(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
  endfunction

  function automatic logic [3:0] hand(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c);
    return 4'((cv(a) + cv(b) + cv(c)) % 10);
  endfunction

  assign pscore = hand(pcard1, pcard2, pcard3);
  assign dscore = hand(dcard1, dcard2, dcard3);

  // Punto banco tableau applied to a dealing order of up to six cards.
  function automatic exp_t model(input logic [5:0][3:0] dk);
    exp_t e;
    int   p, d, t;
    bit   bd;
    e    = '0;
    e.p1 = dk[0]; e.d1 = dk[1]; e.p2 = dk[2]; e.d2 = dk[3]; e.n = 4'd4;
    p    = (cv(dk[0]) + cv(dk[2])) % 10;
    d    = (cv(dk[1]) + cv(dk[3])) % 10;
    if (!(p >= 8 || d >= 8)) begin
      if (p <= 5) begin
        e.p3 = dk[4]; e.n = 4'd5;
        t    = (dk[4] <= 4'd9) ? int'(dk[4]) : 0;
        p    = (p + cv(dk[4])) % 10;
        case (d)
          0, 1, 2: bd = 1'b1;
          3:       bd = (t != 8);
          4:       bd = (t >= 2 && t <= 7);
          5:       bd = (t >= 4 && t <= 7);
          6:       bd = (t >= 6 && t <= 7);
          default: bd = 1'b0;
        endcase
        if (bd) begin
          e.d3 = dk[5]; e.n = 4'd6;
          d    = (d + cv(dk[5])) % 10;
        end
      end else if (d <= 5) begin
        e.d3 = dk[4]; e.n = 4'd5;
        d    = (d + cv(dk[4])) % 10;
      end
    end
    e.pw = (p >= d);
    e.dw = (d >= p);
    return e;
  endfunction

  task automatic run_round(input string name, input logic [5:0][3:0] dk, input bit gaps);
    exp_t e;
    int   idx;
    bit   fin;
    sb.push_back(model(dk));
    @(negedge slow_clock); start = 1'b1;
    @(negedge slow_clock); start = 1'b0;
    vectors++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, player_win, dealer_win, done,
         card_req} !== {26'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s start-clear: got cards %h%h%h/%h%h%h pw%b dw%b done%b req%b exp zeros req1",
               name, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, player_win, dealer_win,
               done, card_req);
    end
    idx = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      if (done) fin = 1'b1;
      else begin
        if (card_req && idx < 6 && (!gaps || $urandom_range(1, 0) == 1)) begin
          card_valid = 1'b1;
          new_card   = dk[idx];
          idx++;
        end else begin
          card_valid = 1'b0;
          new_card   = 4'($urandom_range(15, 0));
        end
        @(negedge slow_clock);
      end
    end
    card_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL %s timeout: done never rose, cards taken %0d exp %0d", name, idx, e.n);
    end
    vectors++;
    if ({pcard1, dcard1, pcard2, dcard2, pcard3, dcard3} !== {e.p1, e.d1, e.p2, e.d2, e.p3, e.d3})
    begin
      miscompares++;
      $display("FAIL %s cards: got p%h%h%h d%h%h%h exp p%h%h%h d%h%h%h", name, pcard1, pcard2,
               pcard3, dcard1, dcard2, dcard3, e.p1, e.p2, e.p3, e.d1, e.d2, e.d3);
    end
    vectors++;
    if ({player_win, dealer_win} !== {e.pw, e.dw}) begin
      miscompares++;
      $display("FAIL %s winner: got pw%b dw%b exp pw%b dw%b", name, player_win, dealer_win,
               e.pw, e.dw);
    end
    vectors++;
    if (idx !== int'(e.n) || card_req !== 1'b0) begin
      miscompares++;
      $display("FAIL %s card count: got %0d req%b exp %0d req0", name, idx, card_req, e.n);
    end
    repeat (3) @(negedge slow_clock);
    vectors++;
    if (done !== 1'b1 || {pcard1, pcard3, dcard3, player_win, dealer_win} !==
        {e.p1, e.p3, e.d3, e.pw, e.dw}) begin
      miscompares++;
      $display("FAIL %s done-hold: got done%b p1%h p3%h d3%h pw%b dw%b exp done1 %h %h %h %b %b",
               name, done, pcard1, pcard3, dcard3, player_win, dealer_win, e.p1, e.p3, e.d3,
               e.pw, e.dw);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; start = 1'b0; card_valid = 1'b0; new_card = 4'd0;
    #3;
    vectors++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, player_win, dealer_win, done,
         card_req} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset: got cards %h%h%h/%h%h%h pw%b dw%b done%b req%b exp all 0", pcard1,
               pcard2, pcard3, dcard1, dcard2, dcard3, player_win, dealer_win, done, card_req);
    end
    @(negedge slow_clock); resetb = 1'b1;
    repeat (3) @(negedge slow_clock);
    vectors++;
    if (card_req !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle-hold: got req%b done%b exp req0 done0", card_req, done);
    end
  endtask

  task automatic test_natural();
    run_round("natural", {4'd0, 4'd0, 4'd3, 4'd5, 4'd2, 4'd4}, 1'b0);
  endtask

  task automatic test_both_draw();
    run_round("both_draw", {4'd7, 4'd8, 4'd12, 4'd3, 4'd10, 4'd2}, 1'b0);
  endtask

  task automatic test_banker_stand_t8();
    run_round("stand_t8", {4'd9, 4'd8, 4'd2, 4'd1, 4'd1, 4'd1}, 1'b0);
  endtask

  task automatic test_player_stand();
    run_round("player_stand", {4'd9, 4'd4, 4'd1, 4'd3, 4'd4, 4'd3}, 1'b1);
  endtask

  task automatic test_tie_and_abort();
    run_round("tie", {4'd5, 4'd5, 4'd7, 4'd7, 4'd11, 4'd10}, 1'b0);
    @(negedge slow_clock); start = 1'b1;
    @(negedge slow_clock); start = 1'b0; card_valid = 1'b1; new_card = 4'd10;
    @(negedge slow_clock); card_valid = 1'b0;
    vectors++;
    if (pcard1 !== 4'd10 || card_req !== 1'b1) begin
      miscompares++;
      $display("FAIL abort-setup: got p1 %h req%b exp p1 a req1", pcard1, card_req);
    end
    resetb = 1'b0;
    #1;
    vectors++;
    if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, card_req, done} !== 26'd0) begin
      miscompares++;
      $display("FAIL abort: got p1 %h req%b done%b exp all 0", pcard1, card_req, done);
    end
    @(negedge slow_clock); resetb = 1'b1;
    repeat (2) @(negedge slow_clock);
    vectors++;
    if (card_req !== 1'b0 || pcard1 !== 4'd0) begin
      miscompares++;
      $display("FAIL abort-idle: got req%b p1 %h exp req0 p1 0", card_req, pcard1);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0][3:0] dk;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 6; i++) dk[i] = 4'($urandom_range(13, 1));
      run_round("random", dk, 1'($urandom_range(1, 0)));
    end
  endtask

`ifdef BACCARAT_CARD_CHECK_EN
  task automatic test_card_check();
    @(negedge slow_clock); start = 1'b1;
    @(negedge slow_clock); start = 1'b0; card_valid = 1'b1; new_card = 4'd0;
    #1;
    vectors++;
    if (bad_card !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_card pulse: got %b exp 1", bad_card);
    end
    @(negedge slow_clock); new_card = 4'd5;
    #1;
    vectors++;
    if (pcard1 !== 4'd0 || card_req !== 1'b1 || bad_card !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_card reject: got p1 %h req%b bad%b exp 0 1 0", pcard1, card_req,
               bad_card);
    end
    @(negedge slow_clock); card_valid = 1'b0;
    vectors++;
    if (pcard1 !== 4'd5) begin
      miscompares++;
      $display("FAIL bad_card recover: got p1 %h exp 5", pcard1);
    end
    resetb = 1'b0;
    @(negedge slow_clock); resetb = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_natural();
    test_both_draw();
    test_banker_stand_t8();
    test_player_stand();
    test_tie_and_abort();
`ifdef BACCARAT_CARD_CHECK_EN
    test_card_check();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
